// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares the single instruction-memory port between the
// fetch stage (read-only) and the program loader/debug port (read/write).
// Ports: clk, rst (async, active-low, 0 = in reset);
//   if_req_i/if_addr_i in, if_stall_o/if_valid_o/if_inst_o out (fetch side);
//   ld_req_i/ld_we_i/ld_addr_i/ld_wdata_i in, ld_gnt_o/ld_rvalid_o/ld_rdata_o
//   out (loader side); mem_addr_o/mem_we_o/mem_d_o out, mem_q_i in (memory,
//   read data valid one cycle after the address).
module imem_port_arbiter #(
    parameter int AW           = 16,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_stall_o,
    output logic          if_valid_o,
    output logic [DW-1:0] if_inst_o,

    input  logic          ld_req_i,
    input  logic          ld_we_i,
    input  logic [AW-1:0] ld_addr_i,
    input  logic [DW-1:0] ld_wdata_i,
    output logic          ld_gnt_o,
    output logic          ld_rvalid_o,
    output logic [DW-1:0] ld_rdata_o,

    output logic [AW-1:0] mem_addr_o,
    output logic          mem_we_o,
    output logic [DW-1:0] mem_d_o,
    input  logic [DW-1:0] mem_q_i
);

    // A limit of 0 still needs a 1-bit counter; it simply never leaves 0.
    localparam int CW =
        (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_LD
    } owner_e;

    owner_e        owner_q, owner_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          starved;
    logic          if_gnt;
    logic          ld_gnt;

    // Grants are masked while reset is held so nothing reaches memory.
    always_comb begin
        starved = (starve_cnt_q == LIMIT);
        if_gnt  = rst & if_req_i & (~ld_req_i | starved);
        ld_gnt  = rst & ld_req_i & ~if_gnt;
    end

    // Address holds its last value on idle cycles.
    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_we_o   = 1'b0;
        mem_d_o    = '0;
        if (if_gnt) begin
            mem_addr_d = if_addr_i;
        end else if (ld_gnt) begin
            mem_addr_d = ld_addr_i;
            mem_we_o   = ld_we_i;
            mem_d_o    = ld_wdata_i;
        end
    end

    // Counts consecutive cycles fetch was refused; saturates at the limit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req_i || if_gnt) begin
            starve_cnt_d = '0;
        end else if (ld_gnt && !starved) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
        end
    end

    // Who owns the read data returning next cycle.
    always_comb begin
        owner_d = OWN_NONE;
        if (if_gnt) begin
            owner_d = OWN_IF;
        end else if (ld_gnt && !ld_we_i) begin
            owner_d = OWN_LD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q      <= OWN_NONE;
            starve_cnt_q <= '0;
            mem_addr_q   <= '0;
        end else begin
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    assign mem_addr_o  = mem_addr_d;
    assign ld_gnt_o    = ld_gnt;
    assign if_stall_o  = rst & if_req_i & ~if_gnt;

    assign if_valid_o  = (owner_q == OWN_IF);
    assign if_inst_o   = if_valid_o ? mem_q_i : '0;
    assign ld_rvalid_o = (owner_q == OWN_LD);
    assign ld_rdata_o  = ld_rvalid_o ? mem_q_i : '0;

endmodule
